// File: rtl/cl_video_pattern_gen.sv
// cl_video_pattern_gen: Camera Link frame/line raster source with selectable test patterns.
// CL_data = {1'b0, dval, fval, lval, pix[23:0]}; every output is driven straight from a register.
module cl_video_pattern_gen #(
   parameter int DATA_W   = 24,
   parameter int H_ACTIVE = 64,
   parameter int H_BLANK  = 8,
   parameter int V_ACTIVE = 4,
   parameter int V_BLANK  = 16,
   parameter int CB_SHIFT = 3,
   parameter int FCNT_W   = 16
) (
   input  logic              CL_clk,
   input  logic              CL_rst,
   input  logic              en,
   input  logic [1:0]        mode,
   output logic [27:0]       CL_data,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int MAXH_A = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
   localparam int MAXH   = (MAXH_A > V_BLANK) ? MAXH_A : V_BLANK;
   localparam int HW     = $clog2(MAXH + 1);
   localparam int VW     = $clog2(V_ACTIVE + 1);

   localparam logic [HW-1:0] HA_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HB_LAST = HW'(H_BLANK - 1);
   localparam logic [HW-1:0] VB_LAST = HW'(V_BLANK - 1);
   localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);

   // Line blank: fval only.
   localparam logic [27:0] LB_WORD = 28'h200_0000;

   typedef enum logic [1:0] {IDLE, VBLANK, LACT, LBLANK} state_t;

   state_t              r_state;
   logic [HW-1:0]       r_h_cnt;
   logic [VW-1:0]       r_v_cnt;
   logic [DATA_W-1:0]   r_run_cnt;
   logic [1:0]          r_mode_q;
   logic [27:0]         r_data;
   logic                r_frame_done;
   logic [FCNT_W-1:0]   r_frame_cnt;

   // Active-pixel word for the pixel position about to be entered.
   function automatic logic [27:0] act_word(input logic [1:0]        m,
                                            input logic [HW-1:0]     h,
                                            input logic [VW-1:0]     v,
                                            input logic [DATA_W-1:0] run);
      logic [DATA_W-1:0] p;
      case (m)
         2'd0:    p = run;
         2'd1:    p = DATA_W'(h);
         2'd2:    p = DATA_W'(v);
         default: p = ((|(h & (HW'(1) << CB_SHIFT))) ^ (|(v & (VW'(1) << CB_SHIFT)))) ? '1 : '0;
      endcase
      return {4'b0111, 24'(p)};
   endfunction

   // Outputs are computed from the next-state values so they change in the cycle the state is entered.
   always_ff @(posedge CL_clk or posedge CL_rst) begin
      if (CL_rst) begin
         r_state      <= IDLE;
         r_h_cnt      <= '0;
         r_v_cnt      <= '0;
         r_run_cnt    <= '0;
         r_mode_q     <= '0;
         r_data       <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_data  <= '0;
               r_h_cnt <= '0;
               if (en) r_state <= VBLANK;
            end
            VBLANK: begin
               if (r_h_cnt == VB_LAST) begin
                  r_state   <= LACT;
                  r_h_cnt   <= '0;
                  r_v_cnt   <= '0;
                  r_mode_q  <= mode;
                  r_run_cnt <= r_run_cnt + DATA_W'(1);
                  r_data    <= act_word(mode, '0, '0, r_run_cnt);
               end else begin
                  r_h_cnt <= r_h_cnt + HW'(1);
                  r_data  <= '0;
               end
            end
            LACT: begin
               if (r_h_cnt == HA_LAST) begin
                  r_h_cnt <= '0;
                  if (r_v_cnt < VA_LAST) begin
                     r_state <= LBLANK;
                     r_data  <= LB_WORD;
                  end else begin
                     r_frame_done <= 1'b1;
                     r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
                     r_data       <= '0;
                     r_state      <= en ? VBLANK : IDLE;
                  end
               end else begin
                  r_h_cnt   <= r_h_cnt + HW'(1);
                  r_run_cnt <= r_run_cnt + DATA_W'(1);
                  r_data    <= act_word(r_mode_q, r_h_cnt + HW'(1), r_v_cnt, r_run_cnt);
               end
            end
            LBLANK: begin
               if (r_h_cnt == HB_LAST) begin
                  r_state   <= LACT;
                  r_h_cnt   <= '0;
                  r_v_cnt   <= r_v_cnt + VW'(1);
                  r_run_cnt <= r_run_cnt + DATA_W'(1);
                  r_data    <= act_word(r_mode_q, '0, r_v_cnt + VW'(1), r_run_cnt);
               end else begin
                  r_h_cnt <= r_h_cnt + HW'(1);
                  r_data  <= LB_WORD;
               end
            end
            default: begin
               r_state <= IDLE;
               r_data  <= '0;
            end
         endcase
      end
   end

   assign CL_data    = r_data;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_cl_video_pattern_gen.sv
// Bench for cl_video_pattern_gen: directed and random stimulus against a frame-position model
// that derives every output from the cycle offset inside the frame period.
module tb_cl_video_pattern_gen;

   localparam int TB_DW  = 8;
   localparam int TB_HA  = 4;
   localparam int TB_HB  = 2;
   localparam int TB_VA  = 3;
   localparam int TB_VB  = 5;
   localparam int TB_CB  = 1;
   localparam int TB_FW  = 16;
   localparam int LINE   = TB_HA + TB_HB;
   localparam int SPAN   = TB_VA * TB_HA + (TB_VA - 1) * TB_HB;
   localparam int PERIOD = TB_VB + SPAN;
   localparam int MASK   = (1 << TB_DW) - 1;

   logic             CL_clk = 1'b0;
   logic             CL_rst = 1'b1;
   logic             en     = 1'b1;
   logic [1:0]       mode   = 2'd0;
   logic [27:0]      CL_data;
   logic             frame_done;
   logic [TB_FW-1:0] frame_cnt;

   cl_video_pattern_gen #(
      .DATA_W  (TB_DW),
      .H_ACTIVE(TB_HA),
      .H_BLANK (TB_HB),
      .V_ACTIVE(TB_VA),
      .V_BLANK (TB_VB),
      .CB_SHIFT(TB_CB),
      .FCNT_W  (TB_FW)
   ) dut (
      .CL_clk    (CL_clk),
      .CL_rst    (CL_rst),
      .en        (en),
      .mode      (mode),
      .CL_data   (CL_data),
      .frame_done(frame_done),
      .frame_cnt (frame_cnt)
   );

   always #5 CL_clk = ~CL_clk;

   // Model state: busy = inside a frame period, pos = cycle offset from the first blank cycle.
   bit          m_busy;
   int          m_pos;
   bit [1:0]    m_mode;
   int          m_run;
   int          m_fcnt;
   logic [27:0] exp_data;
   logic        exp_done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_done = -1;
   int prev_done = -1;

   task automatic model_reset();
      m_busy   = 0;
      m_pos    = 0;
      m_mode   = 0;
      m_run    = 0;
      m_fcnt   = 0;
      exp_data = '0;
      exp_done = 1'b0;
   endtask

   task automatic model_edge(input bit e, input bit [1:0] m);
      int q, ln, col, px;
      exp_done = 1'b0;
      if (m_busy) begin
         if (m_pos == PERIOD - 1) begin
            exp_done = 1'b1;
            m_fcnt++;
            if (e) m_pos = 0;
            else   m_busy = 0;
         end else begin
            m_pos++;
            if (m_pos == TB_VB) m_mode = m;
         end
      end else if (e) begin
         m_busy = 1;
         m_pos  = 0;
      end
      exp_data = '0;
      if (m_busy && m_pos >= TB_VB) begin
         q   = m_pos - TB_VB;
         ln  = q / LINE;
         col = q % LINE;
         if (col < TB_HA) begin
            case (m_mode)
               2'd0:    px = m_run;
               2'd1:    px = col;
               2'd2:    px = ln;
               default: px = (((col >> TB_CB) ^ (ln >> TB_CB)) & 1) != 0 ? MASK : 0;
            endcase
            px       = px & MASK;
            m_run    = (m_run + 1) & MASK;
            exp_data = {4'b0111, 24'(px)};
         end else begin
            exp_data = 28'h200_0000;
         end
      end
   endtask

   task automatic check(input string tag);
      n_tests++;
      assert (CL_data === exp_data) else begin
         n_fail++;
         $error("FAIL %s CL_data cyc=%0d got=%h exp=%h", tag, cyc, CL_data, exp_data);
      end
      n_tests++;
      assert (frame_done === exp_done) else begin
         n_fail++;
         $error("FAIL %s frame_done cyc=%0d got=%b exp=%b", tag, cyc, frame_done, exp_done);
      end
      n_tests++;
      assert (frame_cnt === TB_FW'(m_fcnt)) else begin
         n_fail++;
         $error("FAIL %s frame_cnt cyc=%0d got=%0d exp=%0d", tag, cyc, frame_cnt, TB_FW'(m_fcnt));
      end
   endtask

   // Drive inputs, clock once, advance the model with the sampled inputs, check at the falling edge.
   task automatic step(input bit e, input bit [1:0] m, input string tag);
      en   = e;
      mode = m;
      @(posedge CL_clk);
      cyc++;
      if (CL_rst) model_reset();
      else        model_edge(e, m);
      @(negedge CL_clk);
      check(tag);
      if (frame_done === 1'b1) begin
         prev_done = last_done;
         last_done = cyc;
      end
   endtask

   // Reset raised between edges: outputs must clear before the next rising edge.
   task automatic async_reset(input string tag);
      #2;
      CL_rst = 1'b1;
      #1;
      model_reset();
      check(tag);
      @(posedge CL_clk);
      @(negedge CL_clk);
      check(tag);
      CL_rst = 1'b0;
   endtask

   initial begin
      int  n;
      bit  ren;
      bit [1:0] rmode;
      model_reset();

      // Reset held with en=1: everything stays 0.
      @(negedge CL_clk);
      repeat (4) step(1, 1, "reset_hold");
      CL_rst = 1'b0;

      // Start-up latency, then a single horizontal-ramp frame with en dropped.
      step(1, 1, "startup");
      n = 1;
      while (CL_data[25] !== 1'b1 && n < 20) begin
         step(0, 1, "startup");
         n++;
      end
      n_tests++;
      assert (n === TB_VB + 1) else begin
         n_fail++;
         $error("FAIL fval_rise_latency got=%0d exp=%0d", n, TB_VB + 1);
      end
      repeat (25) step(0, 1, "hramp");

      // Checkerboard frame, then vertical ramp frame.
      step(1, 3, "checker");
      repeat (25) step(0, 3, "checker");
      step(1, 2, "vramp");
      repeat (25) step(0, 2, "vramp");

      // Counter pattern, two back-to-back frames.
      repeat (30) step(1, 0, "counter");
      repeat (25) step(0, 0, "counter");
      n_tests++;
      assert ((last_done - prev_done) === PERIOD) else begin
         n_fail++;
         $error("FAIL done_spacing got=%0d exp=%0d", last_done - prev_done, PERIOD);
      end

      // Mode 1->2 and en drop during line 1: frame completes as horizontal ramp.
      repeat (12) step(1, 1, "midchange");
      repeat (25) step(0, 2, "midchange");

      // Reset at the 3rd active pixel of line 1, then a clean frame.
      repeat (14) step(1, 0, "midreset");
      async_reset("midreset");
      step(1, 0, "after_reset");
      repeat (25) step(0, 0, "after_reset");

      // Random run with occasional asynchronous resets.
      ren   = 1'b1;
      rmode = 2'd0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 19) == 0) ren = ~ren;
         if ($urandom_range(0, 7) == 0)  rmode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 249) == 0) async_reset("random_rst");
         else step(ren, rmode, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
